// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time frame format, majority sampling and
// valid/ready output holding one word plus its error flags.
module uart_rx_cfg #(
    parameter int MAX_BITS    = 9,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Tick,
    input  logic                Rx,
    input  logic                RxEn,
    input  logic [3:0]          NBits,
    input  logic [1:0]          Parity,
    input  logic                StopBits,
    output logic [MAX_BITS-1:0] RxData,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                ParityErr,
    output logic                FrameErr,
    output logic                BreakDet,
    output logic                Overrun,
    output logic                Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] MAXB = 4'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;
    logic                   rx_s;
    logic                   maj;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [3:0]            nbits_q, nbits_d;
    logic [1:0]            par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic                  stopn_q, stopn_d;
    logic [MAX_BITS-1:0]   shreg_q, shreg_d;
    logic                  xor_q, xor_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_q, brk_d;
    logic                  done_q, done_d;

    logic [MAX_BITS-1:0]   data_q;
    logic                  valid_q;
    logic                  perr_out_q;
    logic                  ferr_out_q;
    logic                  brk_out_q;
    logic                  ovr_q;

    logic [3:0]            nbits_eff;
    logic [3:0]            shamt;
    logic                  par_en;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign maj  = (hist_q[0] & hist_q[1]) |
                  (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);

    assign nbits_eff = (NBits >= 4'd5 && NBits <= MAXB) ? NBits : MAXB;
    assign shamt     = MAXB - nbits_q;
    assign par_en    = par_q[0] ^ par_q[1];

    // Synchroniser and history reset high so the line reads idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '1;
            hist_q <= 3'b111;
        end else begin
            sync_q[0] <= Rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (Tick) begin
                hist_q <= {hist_q[1:0], rx_s};
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            par_q   <= '0;
            stop2_q <= 1'b0;
            stopn_q <= 1'b0;
            shreg_q <= '0;
            xor_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            stopn_q <= stopn_d;
            shreg_q <= shreg_d;
            xor_q   <= xor_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        stopn_d = stopn_q;
        shreg_d = shreg_q;
        xor_d   = xor_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE && !RxEn) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (Tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (RxEn && !rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        nbits_d = nbits_eff;
                        par_d   = Parity;
                        stop2_d = StopBits;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_d = '0;
                        if (!maj) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                            shreg_d = '0;
                            xor_d   = 1'b0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            brk_d   = 1'b1;
                            stopn_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL) begin
                        cnt_d   = '0;
                        shreg_d = {maj, shreg_q[MAX_BITS-1:1]};
                        xor_d   = xor_q ^ maj;
                        brk_d   = brk_q & ~maj;
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == nbits_q - 4'd1) begin
                            state_d = par_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == FULL) begin
                        cnt_d   = '0;
                        perr_d  = xor_q ^ maj ^ par_q[1];
                        brk_d   = brk_q & ~maj;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~maj;
                        if (!stopn_q) begin
                            brk_d = brk_q & ~maj;
                        end
                        if (stop2_q && !stopn_q) begin
                            stopn_d = 1'b1;
                        end else begin
                            // Frame ends at mid-stop; word is LSB-justified.
                            done_d  = 1'b1;
                            shreg_d = shreg_q >> shamt;
                            state_d = (ferr_q | ~maj) ? S_WAIT_HIGH
                                                      : S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A load on the accept edge wins over clearing RxValid.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!valid_q || RxReady) begin
                    data_q     <= shreg_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= ferr_q;
                    brk_out_q  <= brk_q;
                    valid_q    <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && RxReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign RxData    = data_q;
    assign RxValid   = valid_q;
    assign ParityErr = perr_out_q;
    assign FrameErr  = ferr_out_q;
    assign BreakDet  = brk_out_q;
    assign Overrun   = ovr_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frames built as per-Tick line levels from
// the frame rules, expected word and flags derived arithmetically.
module tb_uart_rx_cfg;

    localparam int MB = 9;
    localparam int OS = 16;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Tick = 1'b0;
    logic          Rx = 1'b1;
    logic          RxEn = 1'b1;
    logic [3:0]    NBits = 4'd8;
    logic [1:0]    Parity = 2'd0;
    logic          StopBits = 1'b0;
    logic          RxReady = 1'b0;
    logic [MB-1:0] RxData;
    logic          RxValid;
    logic          ParityErr;
    logic          FrameErr;
    logic          BreakDet;
    logic          Overrun;
    logic          Busy;

    int n_tests = 0;
    int n_fail = 0;
    int ovr_cnt = 0;

    logic          q[$];
    int            fin_idx;
    logic [MB-1:0] e_word;
    logic          e_pe, e_fe, e_brk;
    logic [MB-1:0] s_word;
    logic          s_pe, s_fe, s_brk;

    uart_rx_cfg #(
        .MAX_BITS(MB),
        .OVERSAMPLE(OS),
        .SYNC_STAGES(2)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Tick(Tick),
        .Rx(Rx),
        .RxEn(RxEn),
        .NBits(NBits),
        .Parity(Parity),
        .StopBits(StopBits),
        .RxData(RxData),
        .RxValid(RxValid),
        .RxReady(RxReady),
        .ParityErr(ParityErr),
        .FrameErr(FrameErr),
        .BreakDet(BreakDet),
        .Overrun(Overrun),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        if (Overrun) ovr_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic slot(input logic lvl);
        Rx = lvl;
        repeat (3) @(negedge Clk);
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    function automatic int eff(input int n);
        return (n >= 5 && n <= MB) ? n : MB;
    endfunction

    task automatic build(input int nf, input int par,
                         input int sb, input int data,
                         input bit flip, input int slow);
        int nb;
        int ns;
        int pen;
        logic pb;
        logic [MB-1:0] d;
        nb  = eff(nf);
        ns  = sb ? 2 : 1;
        pen = (par == 1 || par == 2) ? 1 : 0;
        d   = MB'(data & ((1 << nb) - 1));
        pb  = (^d) ^ (par == 2) ^ flip;
        q.delete();
        repeat (OS) q.push_back(1'b0);
        for (int k = 0; k < nb; k++)
            repeat (OS) q.push_back(d[k]);
        if (pen != 0) repeat (OS) q.push_back(pb);
        for (int s = 0; s < ns; s++)
            repeat (OS) q.push_back(((slow >> s) & 1) == 0);
        repeat (2 * OS) q.push_back(1'b1);
        fin_idx = OS / 2 + OS * (nb + pen + ns);
        e_word = d;
        e_pe   = (pen != 0) && flip;
        e_fe   = (slow & (sb ? 3 : 1)) != 0;
        e_brk  = (d == 0) && (pen == 0 || pb == 1'b0)
                 && ((slow & 1) != 0);
    endtask

    task automatic play(input int from, input int to,
                        input bit lat, input int chg_at,
                        input int busy_at);
        for (int i = from; i < to; i++) begin
            if (i == chg_at) begin
                NBits    = 4'($urandom_range(0, 15));
                Parity   = 2'($urandom_range(0, 3));
                StopBits = 1'($urandom_range(0, 1));
            end
            slot(q[i]);
            if (i == busy_at) chk("busy", Busy, 1);
            if (lat && i == fin_idx) begin
                chk("lat_pre", RxValid, 0);
                @(negedge Clk);
                chk("lat_post", RxValid, 1);
            end
        end
    endtask

    task automatic play_all(input bit lat);
        play(0, q.size(), lat, -1, -1);
    endtask

    task automatic expect_frame(input string tag);
        int t;
        t = 0;
        while (!RxValid && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk({tag, "_valid"}, RxValid, 1);
        chk({tag, "_data"}, RxData, e_word);
        chk({tag, "_pe"}, ParityErr, e_pe);
        chk({tag, "_fe"}, FrameErr, e_fe);
        chk({tag, "_brk"}, BreakDet, e_brk);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
        chk({tag, "_clr"}, RxValid, 0);
    endtask

    task automatic save_exp();
        s_word = e_word;
        s_pe   = e_pe;
        s_fe   = e_fe;
        s_brk  = e_brk;
    endtask

    task automatic load_exp();
        e_word = s_word;
        e_pe   = s_pe;
        e_fe   = s_fe;
        e_brk  = s_brk;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, RxData, 0);
        chk({tag, "_flags"},
            {RxValid, ParityErr, FrameErr, BreakDet, Overrun, Busy},
            0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Rst_n = 1'b1;
        repeat (4) slot(1'b1);

        build(8, 0, 0, 'hA5, 0, 0);
        play_all(1);
        repeat (20) @(negedge Clk);
        chk("t1_hold", RxValid, 1);
        expect_frame("t1");

        NBits  = 4'd7;
        Parity = 2'd1;
        build(7, 1, 0, 'h53, 0, 0);
        play_all(0);
        expect_frame("t2a");
        build(7, 1, 0, 'h53, 1, 0);
        play_all(0);
        expect_frame("t2b");

        NBits    = 4'd8;
        Parity   = 2'd0;
        StopBits = 1'b1;
        build(8, 0, 1, 'h3C, 0, 2);
        ts = OS * (1 + 8 + 2);
        for (int j = 0; j < OS; j++) q[ts + j] = 1'b0;
        play(0, q.size(), 0, -1, ts + OS - 1);
        expect_frame("t3");
        build(8, 0, 1, 'h11, 0, 0);
        play_all(0);
        expect_frame("t3b");

        StopBits = 1'b0;
        q.delete();
        repeat (20 * OS) q.push_back(1'b0);
        repeat (2 * OS) q.push_back(1'b1);
        e_word = '0;
        e_pe   = 1'b0;
        e_fe   = 1'b1;
        e_brk  = 1'b1;
        play(0, q.size(), 0, -1, 20 * OS - 1);
        expect_frame("t4");
        repeat (2 * OS) slot(1'b1);
        chk("t4_single", RxValid, 0);

        q.delete();
        repeat (3) q.push_back(1'b0);
        repeat (2 * OS) q.push_back(1'b1);
        play(0, q.size(), 0, -1, 2);
        chk("t5_busy", Busy, 0);
        chk("t5_valid", RxValid, 0);

        build(8, 0, 0, 'hFF, 0, 0);
        q[OS * 3 + OS / 2 - 1] = 1'b0;
        play_all(0);
        expect_frame("t5b");

        for (int r = 0; r < 12; r++) begin
            int nf, par, sb, data, slow, nb, g;
            bit flip;
            case ($urandom_range(0, 7))
                0: nf = 0;
                1: nf = 15;
                2: nf = 4;
                default: nf = $urandom_range(5, 9);
            endcase
            par  = $urandom_range(0, 3);
            sb   = $urandom_range(0, 1);
            data = $urandom;
            flip = ($urandom_range(0, 2) == 0);
            slow = ($urandom_range(0, 3) == 0)
                   ? $urandom_range(1, 3) : 0;
            nb   = eff(nf);
            NBits    = 4'(nf);
            Parity   = 2'(par);
            StopBits = 1'(sb);
            build(nf, par, sb, data, flip, slow);
            g = OS + $urandom_range(0, OS * nb - 1);
            q[g] = ~q[g];
            play(0, q.size(), 0, 2 * OS, -1);
            expect_frame("rnd");
        end

        NBits    = 4'd8;
        Parity   = 2'd0;
        StopBits = 1'b0;
        build(8, 0, 0, 'h12, 0, 0);
        save_exp();
        play_all(0);
        build(8, 0, 0, 'h34, 0, 0);
        play_all(0);
        repeat (4) @(negedge Clk);
        chk("t6_ovr", ovr_cnt, 1);
        load_exp();
        expect_frame("t6");

        build(8, 0, 0, 'h5A, 0, 0);
        save_exp();
        play_all(0);
        build(8, 0, 0, 'h66, 0, 0);
        play(0, OS * 4, 0, -1, OS * 4 - 1);
        RxEn = 1'b0;
        @(negedge Clk);
        chk("t7_busy", Busy, 0);
        play(OS * 4, q.size(), 0, -1, -1);
        RxEn = 1'b1;
        repeat (2) slot(1'b1);
        chk("t7_busy2", Busy, 0);
        load_exp();
        expect_frame("t7");

        build(8, 0, 0, 'h77, 0, 0);
        play_all(0);
        build(8, 0, 0, 'h99, 0, 0);
        play(0, OS * 3, 0, -1, OS * 3 - 1);
        Rst_n = 1'b0;
        #1;
        chk_all_zero("t8_rst");
        Rx = 1'b1;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) slot(1'b1);
        chk("t8_valid", RxValid, 0);
        chk("t8_busy", Busy, 0);

        chk("ovr_total", ovr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
